// File: rtl/apb2axi_pkg.sv
// Shared types and constants for the APB-to-AXI bridge read-response path.
package apb2axi_pkg;
    localparam int TAG_NUM       = 8;
    localparam int TAG_W         = $clog2(TAG_NUM);
    localparam int MAX_BEATS_NUM = 16;
    localparam int AXI_ID_W      = 4;
    localparam int AXI_DATA_W    = 32;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [TAG_W-1:0]      tag;
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } rdf_entry_t;

    typedef struct packed {
        logic             is_write;
        logic [TAG_W-1:0] tag;
        logic [1:0]       resp;
        logic             error;
        logic [7:0]       num_beats;
    } completion_entry_t;

    localparam int RDF_W        = $bits(rdf_entry_t);
    localparam int COMPLETION_W = $bits(completion_entry_t);

    typedef enum logic {CTX_IDLE, CTX_ACTIVE} ctx_state_e;

    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/apb2axi_rresp_collector_if.sv
// AXI R channel plus RDF / completion-queue push ports of the response collector.
interface apb2axi_rresp_collector_if;
    import apb2axi_pkg::*;

    logic                  r_valid;
    logic                  r_ready;
    logic [AXI_ID_W-1:0]   r_id;
    logic [AXI_DATA_W-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_last;
    logic                  rdf_valid;
    logic                  rdf_ready;
    rdf_entry_t            rdf_entry;
    logic                  cq_valid;
    logic                  cq_ready;
    completion_entry_t     cq_entry;
    logic                  proto_err;

    modport slave (
        input  r_valid, r_id, r_data, r_resp, r_last, rdf_ready, cq_ready,
        output r_ready, rdf_valid, rdf_entry, cq_valid, cq_entry, proto_err
    );

    modport master (
        output r_valid, r_id, r_data, r_resp, r_last, rdf_ready, cq_ready,
        input  r_ready, rdf_valid, rdf_entry, cq_valid, cq_entry, proto_err
    );
endinterface

// File: rtl/apb2axi_rresp_tag_ctx.sv
// Context of one read tag: burst state, beat count, worst response, sticky error.
// Outputs present the burst summary as it would be with the current beat included.
module apb2axi_rresp_tag_ctx #(
    parameter int MAX_BEATS = apb2axi_pkg::MAX_BEATS_NUM,
    parameter int CNT_W     = $clog2(MAX_BEATS) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_sel,
    input  logic [1:0]       i_resp,
    input  logic             i_last,
    output logic [CNT_W-1:0] o_beats,
    output logic [1:0]       o_worst,
    output logic             o_err,
    output logic             o_ovf
);
    import apb2axi_pkg::*;

    ctx_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]       r_worst, w_worst_nxt;
    logic             r_err, w_err_nxt;
    logic             w_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CTX_IDLE;
            r_cnt   <= '0;
            r_worst <= AXI_RESP_OKAY;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_worst <= w_worst_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_worst_nxt = r_worst;
        w_err_nxt   = r_err;
        w_full      = (r_state == CTX_ACTIVE) && (r_cnt >= CNT_W'(MAX_BEATS));
        o_beats     = (r_state == CTX_ACTIVE) ? r_cnt + 1'b1 : CNT_W'(1);
        o_worst     = resp_max(r_worst, i_resp);
        o_err       = r_err || (i_resp != AXI_RESP_OKAY);
        o_ovf       = i_sel && !i_last && w_full;
        if (i_sel) begin
            if (i_last) begin
                w_state_nxt = CTX_IDLE;
                w_cnt_nxt   = '0;
                w_worst_nxt = AXI_RESP_OKAY;
                w_err_nxt   = 1'b0;
            end else begin
                // an over-long burst keeps counting at the ceiling and is marked bad
                w_state_nxt = CTX_ACTIVE;
                w_cnt_nxt   = w_full ? r_cnt : o_beats;
                w_worst_nxt = o_worst;
                w_err_nxt   = o_err || w_full;
            end
        end
    end
endmodule

// File: rtl/apb2axi_rresp_collector.sv
// Collects AXI R beats into the Read Data FIFO and emits one completion per burst.
// Optional APB2AXI_RRESP_STATS_EN adds saturating beat/completion/error counters.
module apb2axi_rresp_collector #(
    parameter int TAG_NUM   = apb2axi_pkg::TAG_NUM,
    parameter int MAX_BEATS = apb2axi_pkg::MAX_BEATS_NUM
) (
    input  logic                      clk,
    input  logic                      rst,
    apb2axi_rresp_collector_if.slave  bus
`ifdef APB2AXI_RRESP_STATS_EN
    ,
    output logic [15:0]               stat_beats,
    output logic [15:0]               stat_cpl,
    output logic [15:0]               stat_err_cpl
`endif
);
    import apb2axi_pkg::*;

    localparam int CNT_W = $clog2(MAX_BEATS) + 1;

    logic                            w_accept;
    logic                            w_last_ok;
    logic                            w_unused_id;
    logic [TAG_W-1:0]                w_tag;
    logic [TAG_NUM-1:0]              w_sel, w_err, w_ovf;
    logic [TAG_NUM-1:0][CNT_W-1:0]   w_beats;
    logic [TAG_NUM-1:0][1:0]         w_worst;

    logic              r_rdf_vld, r_cq_vld, r_perr;
    rdf_entry_t        r_rdf;
    completion_entry_t r_cq;

    assign w_tag       = bus.r_id[TAG_W-1:0];
    assign w_unused_id = ^bus.r_id[AXI_ID_W-1:TAG_W];
    // a last beat also needs room in the completion slot
    assign w_last_ok   = !bus.r_last || !r_cq_vld || bus.cq_ready;
    assign bus.r_ready = (!r_rdf_vld || bus.rdf_ready) && w_last_ok;
    assign w_accept    = bus.r_valid && bus.r_ready;

    for (genvar g = 0; g < TAG_NUM; g++) begin : g_tag
        assign w_sel[g] = w_accept && (w_tag == TAG_W'(g));
        apb2axi_rresp_tag_ctx #(.MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)) u_ctx (
            .clk     (clk),
            .rst     (rst),
            .i_sel   (w_sel[g]),
            .i_resp  (bus.r_resp),
            .i_last  (bus.r_last),
            .o_beats (w_beats[g]),
            .o_worst (w_worst[g]),
            .o_err   (w_err[g]),
            .o_ovf   (w_ovf[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdf_vld <= 1'b0;
            r_rdf     <= '0;
            r_cq_vld  <= 1'b0;
            r_cq      <= '0;
            r_perr    <= 1'b0;
        end else begin
            r_perr <= |w_ovf;
            if (w_accept) begin
                r_rdf_vld  <= 1'b1;
                r_rdf.tag  <= w_tag;
                r_rdf.data <= bus.r_data;
                r_rdf.resp <= bus.r_resp;
                r_rdf.last <= bus.r_last;
            end else if (bus.rdf_ready) begin
                r_rdf_vld <= 1'b0;
            end
            if (w_accept && bus.r_last) begin
                r_cq_vld           <= 1'b1;
                r_cq.is_write      <= 1'b0;
                r_cq.tag           <= w_tag;
                r_cq.resp          <= w_worst[w_tag];
                r_cq.error         <= w_err[w_tag];
                r_cq.num_beats     <= 8'(w_beats[w_tag]);
            end else if (bus.cq_ready) begin
                r_cq_vld <= 1'b0;
            end
        end
    end

    assign bus.rdf_valid = r_rdf_vld;
    assign bus.rdf_entry = r_rdf;
    assign bus.cq_valid  = r_cq_vld;
    assign bus.cq_entry  = r_cq;
    assign bus.proto_err = r_perr;

`ifdef APB2AXI_RRESP_STATS_EN
    logic w_cpl;
    assign w_cpl = w_accept && bus.r_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_beats   <= '0;
            stat_cpl     <= '0;
            stat_err_cpl <= '0;
        end else begin
            if (w_accept && (stat_beats != 16'hFFFF))                    stat_beats   <= stat_beats + 1'b1;
            if (w_cpl && (stat_cpl != 16'hFFFF))                         stat_cpl     <= stat_cpl + 1'b1;
            if (w_cpl && w_err[w_tag] && (stat_err_cpl != 16'hFFFF))     stat_err_cpl <= stat_err_cpl + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_apb2axi_rresp_collector.sv
// Self-checking bench for apb2axi_rresp_collector: directed scenarios plus a randomized
// interleaved run scored against a per-tag burst model.
module tb_apb2axi_rresp_collector;
    import apb2axi_pkg::*;

    localparam int MAXB = MAX_BEATS_NUM;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    apb2axi_rresp_collector_if bus();

`ifdef APB2AXI_RRESP_STATS_EN
    logic [15:0] stat_beats, stat_cpl, stat_err_cpl;
`endif

    apb2axi_rresp_collector dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef APB2AXI_RRESP_STATS_EN
        ,
        .stat_beats   (stat_beats),
        .stat_cpl     (stat_cpl),
        .stat_err_cpl (stat_err_cpl)
`endif
    );

    int tests = 0;
    int fails = 0;

    rdf_entry_t        exp_rdf[$], act_rdf[$];
    completion_entry_t exp_cq[$],  act_cq[$];
    int exp_perr, act_perr, rule_err;
    int acc_beats, acc_cpl, acc_err;
    int         m_n[TAG_NUM];
    logic [1:0] m_worst[TAG_NUM];
    bit         m_err[TAG_NUM];
    bit         rand_sink = 1'b0;

    // burst-level model: a completion summarises every beat of its tag since the last r_last
    function automatic void model_accept(input logic [TAG_W-1:0] tag, input logic [AXI_DATA_W-1:0] d,
                                         input logic [1:0] resp, input logic last);
        rdf_entry_t re;
        completion_entry_t ce;
        int nb;
        re.tag = tag; re.data = d; re.resp = resp; re.last = last;
        exp_rdf.push_back(re);
        acc_beats++;
        if (resp > m_worst[tag]) m_worst[tag] = resp;
        if (resp != AXI_RESP_OKAY) m_err[tag] = 1'b1;
        if (last) begin
            nb = ((m_n[tag] > MAXB) ? MAXB : m_n[tag]) + 1;
            ce.is_write = 1'b0; ce.tag = tag; ce.resp = m_worst[tag];
            ce.error = m_err[tag] || (m_n[tag] > MAXB); ce.num_beats = 8'(nb);
            exp_cq.push_back(ce);
            acc_cpl++;
            if (ce.error) acc_err++;
            m_n[tag] = 0; m_worst[tag] = 2'b00; m_err[tag] = 1'b0;
        end else begin
            m_n[tag]++;
            if (m_n[tag] > MAXB) exp_perr++;
        end
    endfunction

    function automatic void model_clear();
        for (int t = 0; t < TAG_NUM; t++) begin
            m_n[t] = 0; m_worst[t] = 2'b00; m_err[t] = 1'b0;
        end
        exp_rdf.delete(); act_rdf.delete(); exp_cq.delete(); act_cq.delete();
        exp_perr = 0; act_perr = 0; acc_beats = 0; acc_cpl = 0; acc_err = 0;
    endfunction

    function automatic int rdf_diff();
        int n = (act_rdf.size() > exp_rdf.size()) ? act_rdf.size() - exp_rdf.size()
                                                  : exp_rdf.size() - act_rdf.size();
        for (int i = 0; i < act_rdf.size() && i < exp_rdf.size(); i++)
            if (act_rdf[i] !== exp_rdf[i]) n++;
        return n;
    endfunction

    function automatic int cq_diff();
        int n = (act_cq.size() > exp_cq.size()) ? act_cq.size() - exp_cq.size()
                                                : exp_cq.size() - act_cq.size();
        for (int i = 0; i < act_cq.size() && i < exp_cq.size(); i++)
            if (act_cq[i] !== exp_cq[i]) n++;
        return n;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rdf_valid && bus.rdf_ready) act_rdf.push_back(bus.rdf_entry);
            if (bus.cq_valid && bus.cq_ready)   act_cq.push_back(bus.cq_entry);
            if (bus.proto_err) act_perr++;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rand_sink) begin
            bus.rdf_ready = ($urandom_range(0, 3) != 0);
            bus.cq_ready  = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic idle();
        @(posedge clk); #1;
    endtask

    // called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send_beat(input logic [TAG_W-1:0] tag, input logic [AXI_DATA_W-1:0] d,
                             input logic [1:0] resp, input logic last);
        bit done = 1'b0;
        logic rule;
        bus.r_valid = 1'b1;
        bus.r_id    = AXI_ID_W'($urandom);
        bus.r_id[TAG_W-1:0] = tag;
        bus.r_data  = d; bus.r_resp = resp; bus.r_last = last;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            rule = (!bus.rdf_valid || bus.rdf_ready) && (!last || !bus.cq_valid || bus.cq_ready);
            if (bus.r_ready !== rule) rule_err++;
            if (bus.r_ready === 1'b1) begin
                model_accept(tag, d, resp, last);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.r_valid = 1'b0;
        if (!done) begin
            tests++; fails++;
            $display("FAIL send_beat_timeout: tag %0d not accepted in 200 cycles, required accept", tag);
        end
    endtask

    task automatic drain(input string nm);
        bit ok = 1'b0;
        rand_sink = 1'b0;
        @(posedge clk); #2;
        bus.rdf_ready = 1'b1; bus.cq_ready = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (!bus.rdf_valid && !bus.cq_valid) ok = 1'b1;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s_drain: slots still valid after 100 cycles, required empty", nm);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.r_valid = 1'b0; bus.r_id = '0; bus.r_data = '0; bus.r_resp = '0; bus.r_last = 1'b0;
        bus.rdf_ready = 1'b1; bus.cq_ready = 1'b1;
        model_clear(); rule_err = 0;
        repeat (3) @(negedge clk);
        tests++; if (bus.rdf_valid !== 1'b0) begin fails++; $display("FAIL reset_rdf_valid: got %b, required 0", bus.rdf_valid); end
        tests++; if (bus.cq_valid !== 1'b0)  begin fails++; $display("FAIL reset_cq_valid: got %b, required 0", bus.cq_valid); end
        tests++; if (bus.proto_err !== 1'b0) begin fails++; $display("FAIL reset_proto_err: got %b, required 0", bus.proto_err); end
        tests++; if (bus.rdf_entry !== '0)   begin fails++; $display("FAIL reset_rdf_entry: got %h, required 0", bus.rdf_entry); end
        tests++; if (bus.cq_entry !== '0)    begin fails++; $display("FAIL reset_cq_entry: got %h, required 0", bus.cq_entry); end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        tests++; if (bus.r_ready !== 1'b1)   begin fails++; $display("FAIL reset_r_ready: got %b, required 1", bus.r_ready); end
`ifdef APB2AXI_RRESP_STATS_EN
        tests++;
        if ({stat_beats, stat_cpl, stat_err_cpl} !== '0) begin
            fails++; $display("FAIL reset_stats: got %0d/%0d/%0d, required 0/0/0", stat_beats, stat_cpl, stat_err_cpl);
        end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_four_beat();
        completion_entry_t want;
        int bad_rdf = 0, bad_early = 0;
        want = '{is_write: 1'b0, tag: TAG_W'(3), resp: 2'd0, error: 1'b0, num_beats: 8'd4};
        for (int b = 0; b < 4; b++) begin
            send_beat(TAG_W'(3), AXI_DATA_W'($urandom), AXI_RESP_OKAY, b == 3);
            @(negedge clk);
            if (!bus.rdf_valid || bus.rdf_entry !== exp_rdf[$]) bad_rdf++;
            if (b < 3 && bus.cq_valid) bad_early++;
            if (b == 3) begin
                tests++;
                if (!bus.cq_valid || bus.cq_entry !== want) begin
                    fails++; $display("FAIL four_beat_cpl: got v=%b %h, required v=1 %h", bus.cq_valid, bus.cq_entry, want);
                end
            end
            @(posedge clk); #1;
        end
        tests++; if (bad_rdf != 0)   begin fails++; $display("FAIL four_beat_rdf_timing: %0d beats late/wrong, required 0", bad_rdf); end
        tests++; if (bad_early != 0) begin fails++; $display("FAIL four_beat_early_cpl: %0d early completions, required 0", bad_early); end
        drain("four_beat");
        tests++;
        if (rdf_diff() != 0 || cq_diff() != 0) begin
            fails++; $display("FAIL four_beat_score: rdf diff %0d cq diff %0d, required 0/0", rdf_diff(), cq_diff());
        end
    endtask

    task automatic test_single_beat();
        completion_entry_t want;
        want = '{is_write: 1'b0, tag: TAG_W'(5), resp: 2'd3, error: 1'b1, num_beats: 8'd1};
        send_beat(TAG_W'(5), AXI_DATA_W'($urandom), AXI_RESP_DECERR, 1'b1);
        @(negedge clk);
        tests++;
        if (!bus.cq_valid || bus.cq_entry !== want) begin
            fails++; $display("FAIL single_beat_cpl: got v=%b %h, required v=1 %h", bus.cq_valid, bus.cq_entry, want);
        end
        @(posedge clk); #1;
        drain("single_beat");
    endtask

    task automatic test_interleave();
        completion_entry_t w1, w2;
        act_cq.delete(); exp_cq.delete();
        w2 = '{is_write: 1'b0, tag: TAG_W'(2), resp: 2'd0, error: 1'b0, num_beats: 8'd2};
        w1 = '{is_write: 1'b0, tag: TAG_W'(1), resp: 2'd2, error: 1'b1, num_beats: 8'd3};
        send_beat(TAG_W'(1), AXI_DATA_W'($urandom), AXI_RESP_OKAY,   1'b0);
        send_beat(TAG_W'(2), AXI_DATA_W'($urandom), AXI_RESP_OKAY,   1'b0);
        send_beat(TAG_W'(1), AXI_DATA_W'($urandom), AXI_RESP_SLVERR, 1'b0);
        send_beat(TAG_W'(2), AXI_DATA_W'($urandom), AXI_RESP_OKAY,   1'b1);
        send_beat(TAG_W'(1), AXI_DATA_W'($urandom), AXI_RESP_OKAY,   1'b1);
        drain("interleave");
        tests++;
        if (act_cq.size() != 2) begin
            fails++; $display("FAIL interleave_count: got %0d completions, required 2", act_cq.size());
        end else begin
            tests++; if (act_cq[0] !== w2) begin fails++; $display("FAIL interleave_tag2: got %h, required %h", act_cq[0], w2); end
            tests++; if (act_cq[1] !== w1) begin fails++; $display("FAIL interleave_tag1: got %h, required %h", act_cq[1], w1); end
        end
    endtask

    task automatic test_backpressure();
        rdf_entry_t held;
        logic [AXI_DATA_W-1:0] db;
        int bad_rdy = 0, bad_stable = 0;
        act_rdf.delete(); exp_rdf.delete(); act_cq.delete(); exp_cq.delete();
        bus.rdf_ready = 1'b0;
        send_beat(TAG_W'(6), AXI_DATA_W'($urandom), AXI_RESP_OKAY, 1'b0);
        held = exp_rdf[$];
        db = AXI_DATA_W'($urandom);
        bus.r_valid = 1'b1; bus.r_id = AXI_ID_W'(6); bus.r_data = db;
        bus.r_resp = AXI_RESP_EXOKAY; bus.r_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.r_ready !== 1'b0) bad_rdy++;
            if (!bus.rdf_valid || bus.rdf_entry !== held) bad_stable++;
            @(posedge clk); #1;
        end
        tests++; if (bad_rdy != 0)    begin fails++; $display("FAIL backpressure_r_ready: high in %0d of 5 cycles, required 0", bad_rdy); end
        tests++; if (bad_stable != 0) begin fails++; $display("FAIL backpressure_stable: entry changed in %0d of 5 cycles, required 0", bad_stable); end
        bus.rdf_ready = 1'b1;
        send_beat(TAG_W'(6), db, AXI_RESP_EXOKAY, 1'b1);
        drain("backpressure");
        tests++;
        if (act_rdf.size() != 2 || rdf_diff() != 0 || cq_diff() != 0) begin
            fails++; $display("FAIL backpressure_score: %0d rdf pushes, diff %0d/%0d, required 2 pushes diff 0/0",
                              act_rdf.size(), rdf_diff(), cq_diff());
        end
    endtask

    task automatic test_back_to_back();
        time t0;
        int cyc;
        t0 = $time;
        for (int b = 0; b < 8; b++) send_beat(TAG_W'(0), AXI_DATA_W'($urandom), AXI_RESP_OKAY, b == 7);
        cyc = int'(($time - t0) / 10);
        tests++; if (cyc != 8) begin fails++; $display("FAIL back_to_back_rate: 8 beats took %0d cycles, required 8", cyc); end
        drain("back_to_back");
        tests++;
        if (rdf_diff() != 0 || cq_diff() != 0) begin
            fails++; $display("FAIL back_to_back_score: rdf diff %0d cq diff %0d, required 0/0", rdf_diff(), cq_diff());
        end
    endtask

    task automatic test_overflow();
        int bad_pulse = 0;
        int p0;
        p0 = act_perr;
        for (int b = 0; b < 17; b++) begin
            send_beat(TAG_W'(7), AXI_DATA_W'($urandom), AXI_RESP_OKAY, 1'b0);
            @(negedge clk);
            if (bus.proto_err !== (b == 16)) bad_pulse++;
            @(posedge clk); #1;
        end
        tests++; if (bad_pulse != 0) begin fails++; $display("FAIL overflow_pulse: %0d wrong proto_err cycles, required 0", bad_pulse); end
        send_beat(TAG_W'(7), AXI_DATA_W'($urandom), AXI_RESP_OKAY, 1'b1);
        @(negedge clk);
        tests++;
        if (!bus.cq_valid || bus.cq_entry.error !== 1'b1 || bus.cq_entry !== exp_cq[$]) begin
            fails++; $display("FAIL overflow_cpl: got v=%b %h, required v=1 %h (error 1)", bus.cq_valid, bus.cq_entry, exp_cq[$]);
        end
        @(posedge clk); #1;
        drain("overflow");
        tests++;
        if (act_perr - p0 != 1) begin fails++; $display("FAIL overflow_count: %0d proto_err pulses, required 1", act_perr - p0); end
    endtask

    task automatic test_reset_mid();
        completion_entry_t want;
        want = '{is_write: 1'b0, tag: TAG_W'(4), resp: 2'd0, error: 1'b0, num_beats: 8'd2};
        send_beat(TAG_W'(4), AXI_DATA_W'($urandom), AXI_RESP_OKAY, 1'b0);
        send_beat(TAG_W'(4), AXI_DATA_W'($urandom), AXI_RESP_OKAY, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.rdf_valid !== 1'b0 || bus.cq_valid !== 1'b0 || bus.proto_err !== 1'b0) begin
            fails++; $display("FAIL reset_mid_valids: rdf %b cq %b perr %b, required 0 0 0", bus.rdf_valid, bus.cq_valid, bus.proto_err);
        end
        model_clear();
        @(posedge clk); #1; rst = 1'b0;
        repeat (3) idle();
        tests++; if (act_cq.size() != 0) begin fails++; $display("FAIL reset_mid_no_cpl: got %0d completions, required 0", act_cq.size()); end
        send_beat(TAG_W'(4), AXI_DATA_W'($urandom), AXI_RESP_OKAY, 1'b0);
        send_beat(TAG_W'(4), AXI_DATA_W'($urandom), AXI_RESP_OKAY, 1'b1);
        @(negedge clk);
        tests++;
        if (!bus.cq_valid || bus.cq_entry !== want) begin
            fails++; $display("FAIL reset_mid_cpl: got v=%b %h, required v=1 %h", bus.cq_valid, bus.cq_entry, want);
        end
        @(posedge clk); #1;
        drain("reset_mid");
    endtask

    task automatic test_random();
        int rem[TAG_NUM];
        int t;
        logic [1:0] rs;
        exp_rdf.delete(); act_rdf.delete(); exp_cq.delete(); act_cq.delete();
        rule_err = 0;
        for (int i = 0; i < TAG_NUM; i++) rem[i] = 0;
        rand_sink = 1'b1;
        for (int k = 0; k < 400; k++) begin
            t = $urandom_range(0, TAG_NUM - 1);
            if (rem[t] == 0) rem[t] = ($urandom_range(0, 9) == 0) ? $urandom_range(17, 19) : $urandom_range(1, 6);
            rs = ($urandom_range(0, 3) == 0) ? 2'($urandom) : AXI_RESP_OKAY;
            send_beat(TAG_W'(t), AXI_DATA_W'($urandom), rs, rem[t] == 1);
            rem[t]--;
            if ($urandom_range(0, 3) == 0) idle();
        end
        for (int i = 0; i < TAG_NUM; i++)
            while (rem[i] > 0) begin
                send_beat(TAG_W'(i), AXI_DATA_W'($urandom), AXI_RESP_OKAY, rem[i] == 1);
                rem[i]--;
            end
        drain("random");
        tests++; if (rdf_diff() != 0) begin fails++; $display("FAIL random_rdf: %0d entries differ (got %0d, model %0d)", rdf_diff(), act_rdf.size(), exp_rdf.size()); end
        tests++; if (cq_diff() != 0)  begin fails++; $display("FAIL random_cq: %0d entries differ (got %0d, model %0d)", cq_diff(), act_cq.size(), exp_cq.size()); end
        tests++; if (act_perr != exp_perr) begin fails++; $display("FAIL random_proto_err: got %0d pulses, required %0d", act_perr, exp_perr); end
        tests++; if (rule_err != 0) begin fails++; $display("FAIL random_r_ready_rule: %0d cycles off rule, required 0", rule_err); end
`ifdef APB2AXI_RRESP_STATS_EN
        tests++;
        if (stat_beats != 16'(acc_beats) || stat_cpl != 16'(acc_cpl) || stat_err_cpl != 16'(acc_err)) begin
            fails++; $display("FAIL random_stats: got %0d/%0d/%0d, required %0d/%0d/%0d",
                              stat_beats, stat_cpl, stat_err_cpl, acc_beats, acc_cpl, acc_err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_four_beat();
        test_single_beat();
        test_interleave();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
